decode_scan_reg: RTL
====================

Name: decode_scan_reg

Overview:
- Parametrised, registered successor of the combinational 5-to-32 decoder.
- Drives 2^IN_W select lines in one of four modes:
  - one-hot decode
  - thermometer decode
  - timed auto-scan, with a programmable dwell per line
  - hold
- Used as the row/digit select driver for scanned displays and LED banks, and as a general registered line decoder.

Parameters:
- IN_W, 5, width of index input x; output width OUT_N = 2**IN_W (derived, not overridable).
- DWELL_W, 8, width of dwell-count input and internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  enable; 0 forces y to zero and freezes idx and the dwell counter.
- mode  input  2  00 one-hot, 01 thermometer, 10 scan, 11 hold.
- x  input  IN_W  index for decode modes; load value in scan mode.
- load  input  1  scan mode only: idx <= x and dwell counter cleared.
- dwell  input  DWELL_W  scan mode: each line is held for dwell+1 cycles.
- y  output  OUT_N  registered select lines.
- idx  output  IN_W  registered current index.
- valid  output  1  registered copy of en.
- wrap  output  1  one-cycle pulse when scan index wraps from OUT_N-1 to 0.

Behaviour:
- Reset (rst=1 at clock edge):
  - y=0, idx=0, internal cnt=0, valid=0, wrap=0.
  - rst overrides all other inputs in the same cycle.
- All outputs are registered. Combinational input-to-output paths are prohibited.
- valid <= en every cycle (when not in reset).
- en=0:
  - y <= 0, wrap <= 0.
  - idx and cnt hold, in all modes.
- Mode 00 (one-hot), en=1:
  - idx <= x; y <= one-hot(x), i.e. y[i]=1 iff i==x.
  - cnt <= 0, wrap <= 0.
  - Latency 1 cycle.
- Mode 01 (thermometer), en=1:
  - idx <= x; y[i] <= 1 iff i<=x. x=0 gives y=1; x=OUT_N-1 gives all ones.
  - cnt <= 0, wrap <= 0.
- Mode 10 (scan), en=1, evaluated in this priority order:
  - load=1: idx <= x, cnt <= 0, wrap <= 0.
  - else if cnt >= dwell:
    - cnt <= 0; idx <= idx+1 modulo OUT_N.
    - wrap <= 1 iff old idx == OUT_N-1, else 0.
  - else: cnt <= cnt+1, wrap <= 0.
- Scan-mode output alignment:
  - y <= one-hot(next idx), so y always equals one-hot(idx) in the same cycle.
  - dwell=0 advances every cycle.
  - dwell is sampled live. Using >= rather than == means a dwell value lowered below the current cnt causes an advance on the next edge, with no lockup.
  - cnt never exceeds 2^DWELL_W-1; its wrap is unreachable because of the >= compare.
- Mode 11 (hold), en=1: y, idx and cnt hold; wrap <= 0.
- Mode switching:
  - On entering scan, counting starts from the current idx with cnt as left by the previous mode (0 after 00/01).
  - Leaving scan discards the dwell phase only via the 00/01 cnt clear.
- x values are always in range by width. No out-of-range handling exists.
- Reset mid-scan returns to idx=0, cnt=0 on the next edge. The first advance then comes dwell+1 cycles after rst deasserts.

Test Plan:
- Reset: assert rst 2 cycles with en=1, mode=10 -> y=0, idx=0, valid=0, wrap=0. Release: the first edge with en=1 gives y=32'h1, valid=1.
- One-hot sweep: mode=00, en=1, x=0..31 one per cycle -> one cycle later y=1<<x and idx=x. Then en=0 -> y=0 next cycle, idx holds 31.
- Thermometer: mode=01, x=0 -> y=32'h1; x=4 -> y=32'h1F; x=31 -> y=32'hFFFF_FFFF.
- Scan dwell and wrap: mode=10, dwell=2, load with x=30 for one cycle.
  - Expected: idx=30 for 3 cycles, then 31 for 3 cycles, then 0.
  - wrap=1 only in the cycle idx becomes 0; y tracks one-hot(idx) every cycle.
- Scan boundaries:
  - dwell=0 -> idx increments every cycle.
  - Lower dwell from 9 to 1 while cnt=5 -> idx advances on the next edge.
  - load=1 coinciding with a due advance -> idx=x, cnt=0, wrap=0.
- Hold and enable: in scan at idx=7, switch to mode=11 for 10 cycles -> idx=7, y=1<<7 throughout.
  - Then en=0 for 3 cycles -> y=0, idx=7.
  - Then mode=10, en=1 -> scan resumes from 7.

Source files
------------

// File: rtl/decode_scan_reg.sv
// Registered line decoder with one-hot, thermometer, timed auto-scan and hold modes.
// Every output comes from a flop; nothing passes combinationally from an input to an output.
module decode_scan_reg #(
    parameter int IN_W    = 5,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [IN_W-1:0]      x,
    input  logic                 load,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**IN_W-1:0]   y,
    output logic [IN_W-1:0]      idx,
    output logic                 valid,
    output logic                 wrap
);
    localparam int OUT_N = 2**IN_W;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERMO = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

    logic [OUT_N-1:0]   r_y;
    logic [IN_W-1:0]    r_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_valid;
    logic               r_wrap;

    logic [OUT_N-1:0]   w_y_next;
    logic [IN_W-1:0]    w_idx_next;
    logic [DWELL_W-1:0] w_cnt_next;
    logic               w_wrap_next;

    logic [IN_W-1:0]    w_scan_idx;
    logic [DWELL_W-1:0] w_scan_cnt;
    logic               w_scan_wrap;
    logic               w_scan_due;
    logic [OUT_N-1:0]   w_onehot_x;
    logic [OUT_N-1:0]   w_thermo_x;
    logic [OUT_N-1:0]   w_onehot_scan;

    // >= rather than == so a dwell lowered below the running count advances at once.
    assign w_scan_due = (r_cnt >= dwell);

    always_comb begin
        w_scan_idx  = r_idx;
        w_scan_cnt  = r_cnt + DWELL_W'(1);
        w_scan_wrap = 1'b0;
        if (load) begin
            w_scan_idx = x;
            w_scan_cnt = '0;
        end else if (w_scan_due) begin
            w_scan_idx  = r_idx + IN_W'(1);
            w_scan_cnt  = '0;
            w_scan_wrap = (r_idx == IN_W'(OUT_N - 1));
        end
    end

    generate
        for (genvar gi = 0; gi < OUT_N; gi++) begin : g_dec
            assign w_onehot_x[gi]    = (x == IN_W'(gi));
            assign w_thermo_x[gi]    = (IN_W'(gi) <= x);
            assign w_onehot_scan[gi] = (w_scan_idx == IN_W'(gi));
        end
    endgenerate

    always_comb begin
        w_y_next    = r_y;
        w_idx_next  = r_idx;
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        if (!en) begin
            w_y_next = '0;
        end else begin
            case (mode)
                MODE_ONEHOT: begin
                    w_idx_next = x;
                    w_cnt_next = '0;
                    w_y_next   = w_onehot_x;
                end
                MODE_THERMO: begin
                    w_idx_next = x;
                    w_cnt_next = '0;
                    w_y_next   = w_thermo_x;
                end
                MODE_SCAN: begin
                    w_idx_next  = w_scan_idx;
                    w_cnt_next  = w_scan_cnt;
                    w_wrap_next = w_scan_wrap;
                    w_y_next    = w_onehot_scan;
                end
                default: begin
                    // hold: y, idx and cnt keep their values
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_y     <= w_y_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_valid <= en;
            r_wrap  <= w_wrap_next;
        end
    end

    assign y     = r_y;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule
